// File: rtl/video_fetch_arb.sv
// Purpose: slot-synchronous fetch arbiter sharing the 64-bit video read port
//          between the shifter and the Viking card.
// Latency: grant at a slot-start edge; rdata/ack visible DATA_LAT+1 cycles after a request present at that edge.
// Backpressure: requesters hold req/addr until ack. A request missing a slot waits 16 cycles for the next slot.
//
// Ports:
//   clk_32, reset (sync, active-high), clk_8_en, bus_cycle - timing inputs
//   viking_enable                                          - gates Viking requests
//   s_req/s_addr/s_ack                                     - shifter request side
//   v_req/v_addr/v_ack                                     - Viking request side
//   vaddr/read/data                                        - memory controller video port
//   rdata                                                  - registered read data, shared by both requesters
//   busy                                                   - fetch in flight
//   owner                                                  - last granted requester (0 shifter, 1 Viking)
module video_fetch_arb #(
  parameter logic [1:0] SLOT_CYCLE = 2'd0,
  parameter int         DATA_LAT   = 6,
  parameter int         PRIO_LIMIT = 3
) (
  input  logic        clk_32,
  input  logic        reset,
  input  logic        clk_8_en,
  input  logic [1:0]  bus_cycle,
  input  logic        viking_enable,
  input  logic        s_req,
  input  logic [22:0] s_addr,
  output logic        s_ack,
  input  logic        v_req,
  input  logic [22:0] v_addr,
  output logic        v_ack,
  output logic [22:0] vaddr,
  output logic        read,
  input  logic [63:0] data,
  output logic [63:0] rdata,
  output logic        busy,
  output logic        owner
);

  localparam logic [3:0] LAT_LD = 4'(DATA_LAT);
  // Counter value seen at edge G+4: the strobe drops there, giving 4 high cycles.
  localparam logic [3:0] RD_END = 4'(DATA_LAT - 3);
  localparam logic [2:0] PRIO_L = 3'(PRIO_LIMIT);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [2:0] r_streak;
  logic       r_win;

  logic w_slot;
  logic w_s_elig;
  logic w_v_elig;
  logic w_grant;
  logic w_win_v;
  logic w_data_edge;
  logic w_read_end;

  assign w_slot     = clk_8_en && (bus_cycle == SLOT_CYCLE);
  assign w_s_elig   = s_req;
  assign w_v_elig   = v_req && viking_enable;
  assign w_read_end = (r_state == ST_WAIT) && (r_cnt == RD_END);
  assign busy       = (r_state == ST_WAIT);

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_win_v     = 1'b0;
    w_data_edge = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_slot && (w_s_elig || w_v_elig)) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_WAIT;
          // Viking wins unless the shifter is pending and the streak is spent.
          w_win_v     = w_v_elig && (!w_s_elig || (r_streak < PRIO_L));
        end
      end
      ST_WAIT: begin
        // Slot starts seen here are ignored; r_cnt==1 marks edge G+DATA_LAT.
        if (r_cnt == 4'd1) begin
          w_data_edge = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_32) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_streak <= 3'd0;
      r_win    <= 1'b0;
      vaddr    <= 23'd0;
      read     <= 1'b0;
      rdata    <= 64'd0;
      s_ack    <= 1'b0;
      v_ack    <= 1'b0;
      owner    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      s_ack   <= 1'b0;
      v_ack   <= 1'b0;

      if (w_grant) begin
        vaddr <= w_win_v ? v_addr : s_addr;
        read  <= 1'b1;
        owner <= w_win_v;
        r_win <= w_win_v;
        r_cnt <= LAT_LD;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
        if (w_read_end) read <= 1'b0;
        if (w_data_edge) begin
          rdata <= data;
          if (r_win) v_ack <= 1'b1;
          else       s_ack <= 1'b1;
        end
      end

      // A disabled card forfeits its accumulated priority.
      if (!viking_enable) begin
        r_streak <= 3'd0;
      end else if (w_grant) begin
        if (!w_win_v)      r_streak <= 3'd0;
        else if (w_s_elig) r_streak <= r_streak + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_video_fetch_arb.sv
module tb_video_fetch_arb;

  logic        clk_32 = 1'b0;
  logic        reset = 1'b1;
  logic        clk_8_en = 1'b1;
  logic [1:0]  bus_cycle = 2'd0;
  logic        viking_enable = 1'b0;
  logic        s_req = 1'b0;
  logic [22:0] s_addr = '0;
  logic        s_ack;
  logic        v_req = 1'b0;
  logic [22:0] v_addr = '0;
  logic        v_ack;
  logic [22:0] vaddr;
  logic        read;
  logic [63:0] data = '0;
  logic [63:0] rdata;
  logic        busy;
  logic        owner;

  video_fetch_arb #(.SLOT_CYCLE(2'd0), .DATA_LAT(6), .PRIO_LIMIT(3)) dut (
    .clk_32(clk_32), .reset(reset), .clk_8_en(clk_8_en), .bus_cycle(bus_cycle),
    .viking_enable(viking_enable),
    .s_req(s_req), .s_addr(s_addr), .s_ack(s_ack),
    .v_req(v_req), .v_addr(v_addr), .v_ack(v_ack),
    .vaddr(vaddr), .read(read), .data(data), .rdata(rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk_32 = ~clk_32;

  typedef struct { bit v; logic [63:0] d; int cyc; } ack_t;
  typedef struct { bit v; logic [22:0] a; int cyc; } gnt_t;

  ack_t ack_q[$];
  gnt_t gnt_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;   // index of the most recent clock edge
  int ph     = 0;   // phase (mod 16) of the upcoming edge; 0 = slot start

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Timebase: 8 MHz enable every 4th cycle, bus_cycle advancing on each enable.
  initial begin
    forever begin
      @(posedge clk_32);
      #1;
      cyc++;
      ph = (ph + 1) % 16;
      clk_8_en = (ph % 4 == 0);
      if (ph % 4 == 0) bus_cycle = 2'(ph / 4);
    end
  end

  // Returns just before the next slot-start edge (inputs driven now are sampled there).
  task automatic to_slot();
    while (ph != 0) begin
      @(posedge clk_32);
      #2;
    end
  endtask

  task automatic run_wait(input int n);
    repeat (n) @(posedge clk_32);
    #2;
  endtask

  task automatic push_gnt(input bit v, input logic [22:0] a, input int c);
    gnt_t g;
    g.v = v; g.a = a; g.cyc = c;
    gnt_q.push_back(g);
  endtask

  task automatic push_ack(input bit v, input logic [63:0] d, input int c);
    ack_t e;
    e.v = v; e.d = d; e.cyc = c;
    ack_q.push_back(e);
  endtask

  // Monitor: compares every grant (read rising) and every ack against the scoreboard.
  initial begin
    logic prev_read;
    logic rise;
    prev_read = 1'b0;
    forever begin
      @(negedge clk_32);
      rise = (read === 1'b1) && (prev_read !== 1'b1);
      if (rise) begin
        if (gnt_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_grant: owner=%0d vaddr=%0h at cycle %0d, none expected", owner, vaddr, cyc);
        end else begin
          gnt_t g;
          g = gnt_q.pop_front();
          chk("grant_owner_vaddr", {owner, vaddr}, {g.v, g.a});
          chk("grant_cycle", 128'(cyc), 128'(g.cyc));
        end
      end
      if (s_ack === 1'b1 || v_ack === 1'b1) begin
        chk("ack_not_with_read_rise", 128'(rise), 128'(0));
        if (ack_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_ack: s_ack=%0b v_ack=%0b at cycle %0d, none expected", s_ack, v_ack, cyc);
        end else begin
          ack_t e;
          e = ack_q.pop_front();
          chk("ack_id_rdata", {s_ack, v_ack, rdata}, {~e.v, e.v, e.d});
          chk("ack_cycle", 128'(cyc), 128'(e.cyc));
        end
      end
      prev_read = read;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    logic seen;

    // ---- Reset sequencing with random request activity ----
    repeat (3) begin
      @(posedge clk_32);
      #2;
      s_req = 1'($urandom_range(0, 1));
      v_req = 1'($urandom_range(0, 1));
      viking_enable = 1'($urandom_range(0, 1));
      s_addr = 23'($urandom);
      v_addr = 23'($urandom);
      @(negedge clk_32);
      chk("reset_outputs", {read, s_ack, v_ack, busy, owner, vaddr, rdata}, '0);
    end
    viking_enable = 1'b0;
    v_req = 1'b0;
    s_req = 1'b1;
    s_addr = 23'h00ABCD;
    reset = 1'b0;
    @(negedge clk_32);
    chk("post_reset_outputs", {read, s_ack, v_ack, busy, owner, vaddr, rdata}, '0);
    to_slot();
    c = cyc;
    data = 64'h1234_5678_9ABC_DEF0;
    push_gnt(1'b0, 23'h00ABCD, c + 1);
    push_ack(1'b0, 64'h1234_5678_9ABC_DEF0, c + 7);
    run_wait(8);
    s_req = 1'b0;

    // ---- Shifter-only fetch with Viking disabled but requesting ----
    to_slot();
    c = cyc;
    viking_enable = 1'b0;
    v_req = 1'b1;
    v_addr = 23'h7FFFFF;
    s_req = 1'b1;
    s_addr = 23'h012345;
    data = 64'hDEAD_BEEF_0123_4567;
    push_gnt(1'b0, 23'h012345, c + 1);
    push_ack(1'b0, 64'hDEAD_BEEF_0123_4567, c + 7);
    @(posedge clk_32);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_32);
      chk("read_window", {read, busy, vaddr}, {1'b1, 1'b1, 23'h012345});
    end
    @(negedge clk_32);
    chk("read_cleared_g4", {read, busy, vaddr}, {1'b0, 1'b1, 23'h012345});
    run_wait(3);
    s_req = 1'b0;
    v_req = 1'b0;

    // ---- Fairness: both requesting, PRIO_LIMIT=3 -> V,V,V,S,V,V,V,S ----
    viking_enable = 1'b1;
    s_req = 1'b1;
    s_addr = 23'h055555;
    v_req = 1'b1;
    v_addr = 23'h02AAAA;
    for (int k = 0; k < 8; k++) begin
      to_slot();
      c = cyc;
      data = 64'h0123_4567_89AB_0000 | 64'(k);
      if (k % 4 == 3) begin
        push_gnt(1'b0, 23'h055555, c + 1);
        push_ack(1'b0, 64'h0123_4567_89AB_0000 | 64'(k), c + 7);
      end else begin
        push_gnt(1'b1, 23'h02AAAA, c + 1);
        push_ack(1'b1, 64'h0123_4567_89AB_0000 | 64'(k), c + 7);
      end
      run_wait(1);
    end
    run_wait(7);
    s_req = 1'b0;
    v_req = 1'b0;

    // ---- Late request: raised one cycle after a slot start ----
    viking_enable = 1'b0;
    to_slot();
    @(posedge clk_32);
    #2;
    c = cyc;
    s_req = 1'b1;
    s_addr = 23'h003210;
    data = 64'hFEED_FACE_CAFE_F00D;
    push_gnt(1'b0, 23'h003210, c + 16);
    push_ack(1'b0, 64'hFEED_FACE_CAFE_F00D, c + 22);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_32);
      if (read !== 1'b0) seen = 1'b1;
    end
    chk("late_req_no_early_read", 128'(seen), 128'(0));
    run_wait(9);
    s_req = 1'b0;

    // ---- Reset mid-fetch of a Viking grant ----
    viking_enable = 1'b1;
    to_slot();
    c = cyc;
    v_req = 1'b1;
    v_addr = 23'h0600DD;
    data = 64'hAAAA_BBBB_CCCC_DDDD;
    push_gnt(1'b1, 23'h0600DD, c + 1);
    run_wait(3);
    reset = 1'b1;
    v_req = 1'b0;
    @(posedge clk_32);
    #2;
    reset = 1'b0;
    @(negedge clk_32);
    chk("abort_outputs", {read, busy, s_ack, v_ack, owner, vaddr, rdata}, '0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_32);
      if (s_ack !== 1'b0 || v_ack !== 1'b0 || read !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_ack", 128'(seen), 128'(0));

    // ---- viking_enable cleared during a Viking fetch ----
    viking_enable = 1'b1;
    to_slot();
    c = cyc;
    v_req = 1'b1;
    v_addr = 23'h011111;
    s_req = 1'b1;
    s_addr = 23'h022222;
    data = 64'h5555_6666_7777_8888;
    push_gnt(1'b1, 23'h011111, c + 1);
    push_ack(1'b1, 64'h5555_6666_7777_8888, c + 7);
    push_gnt(1'b0, 23'h022222, c + 17);
    push_ack(1'b0, 64'h9999_0000_1111_2222, c + 23);
    run_wait(2);
    viking_enable = 1'b0;
    run_wait(13);
    data = 64'h9999_0000_1111_2222;
    run_wait(9);
    s_req = 1'b0;
    v_req = 1'b0;

    run_wait(4);
    chk("grant_queue_drained", 128'(gnt_q.size()), 128'(0));
    chk("ack_queue_drained", 128'(ack_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/video_fetch_arb.md
# video_fetch_arb

Video memory fetch arbiter for the 64-bit video read port. It sits between the memory controller's video slot and two fetch engines: the ST(E) shifter and the Viking 1280x1024 card. It replaces the static viking_enable mux with a slot-synchronous request/acknowledge scheduler. The shifter keeps being served, with bounded latency, while Viking is active.

## Interface
- SLOT_CYCLE, 2'd0, bus_cycle value that marks the video slot
- DATA_LAT, 6, clk_32 edges from slot-start edge to the edge that samples data; legal range 4..15
- PRIO_LIMIT, 3, max consecutive Viking grants while a shifter request is pending; legal range 1..7
- clk_32  in  1  31.875 MHz system clock; the only clock
- reset  in  1  synchronous, active-high reset
- clk_8_en  in  1  8 MHz enable, one clk_32 cycle every 4
- bus_cycle  in  2  current bus cycle, valid when clk_8_en=1
- viking_enable  in  1  Viking card enabled; when 0, Viking requests are ignored
- s_req  in  1  shifter fetch request, level
- s_addr  in  23  shifter word address
- s_ack  out  1  one-cycle pulse: shifter fetch complete, rdata valid
- v_req  in  1  Viking fetch request, level
- v_addr  in  23  Viking word address
- v_ack  out  1  one-cycle pulse: Viking fetch complete, rdata valid
- vaddr  out  23  address to memory controller
- read  out  1  video read strobe to memory controller
- data  in  64  read data from memory
- rdata  out  64  registered read data, shared by both requesters
- busy  out  1  fetch in flight (state != IDLE)
- owner  out  1  last granted requester: 0 = shifter, 1 = Viking

## Operation
- Slot start: a clk_32 edge where clk_8_en=1 and bus_cycle==SLOT_CYCLE. There is one slot per 16 clk_32 cycles.
- FSM states:
  - IDLE, moves to WAIT at a slot start with an eligible request.
  - WAIT, moves to IDLE at the data edge.
- No other transitions. A slot start seen in WAIT is skipped; with legal DATA_LAT this cannot occur.
- Eligible requests: s_req always; v_req only if viking_enable=1. Both are sampled at the slot-start edge.
- Arbitration at the grant edge, where streak is a 3-bit counter:
  - Only s_req eligible: grant shifter, streak<=0.
  - Only v_req eligible: grant Viking, streak unchanged.
  - Both eligible and streak<PRIO_LIMIT: grant Viking, streak<=streak+1.
  - Both eligible and streak==PRIO_LIMIT: grant shifter, streak<=0.
- On grant:
  - vaddr<=winner address; read<=1; owner<=winner.
  - The winner id is latched internally; a down-counter is loaded with DATA_LAT.
- read clears at the 4th edge after the grant edge, so it is high for exactly 4 cycles. vaddr holds until the next grant.
- Data edge (DATA_LAT edges after grant):
  - rdata<=data.
  - The latched winner's ack<=1 for one cycle.
  - State<=IDLE.
- A requester holds req/addr stable until its ack. It may drop req before ack; the fetch still completes and the ack still pulses.
- A viking_enable change during WAIT does not affect the in-flight fetch. The ack still goes to the latched winner, and the new value applies at the next grant. streak<=0 whenever viking_enable=0.
- Reset values: read=0, vaddr=0, rdata=0, s_ack=0, v_ack=0, busy=0, owner=0, streak=0, state IDLE.
- Reset asserted in WAIT aborts the fetch: no ack is issued, and read is 0 after the reset edge.

## Timing
- Grant edge G (slot start). read=1 and vaddr are valid from G through G+3 and cleared by edge G+4.
- Data is sampled at edge G+DATA_LAT. rdata and ack are visible in the cycle after that edge.
- busy=1 from after G until after G+DATA_LAT.
- Request-to-ack latency:
  - Minimum: DATA_LAT+1 cycles, when the request is present at a slot start.
  - Worst case for the shifter with Viking saturating: (PRIO_LIMIT+1)*16 + DATA_LAT + 1 cycles.
- A request arriving after the slot-start edge waits for the next slot, 16 cycles later.
- ack never pulses in the same cycle as read rises for a new grant.

## Test plan
- Reset sequencing:
  - Stimulus: reset high for 3 cycles during random req activity.
  - Response: all outputs are 0 through reset and the cycle after.
  - Response: first grant happens only at the first slot start after release.
- Shifter-only fetch:
  - Stimulus: viking_enable=0, v_req=1, s_req=1, s_addr=23'h012345, data=64'hDEAD_BEEF_0123_4567.
  - Response: vaddr=23'h012345 and read=1 for 4 cycles.
  - Response: s_ack pulses once at G+7 with rdata=64'hDEAD_BEEF_0123_4567; v_ack never pulses.
- Fairness:
  - Stimulus: viking_enable=1, PRIO_LIMIT=3, s_req and v_req held high over 8 slots.
  - Response: owner sequence is V,V,V,S,V,V,V,S, with one ack per slot to the matching requester.
- Late request:
  - Stimulus: s_req raised one cycle after a slot start.
  - Response: no read until the next slot start, 16 cycles later; s_ack follows 7 cycles after that.
- Reset mid-fetch:
  - Stimulus: reset pulsed at G+3 of a Viking fetch.
  - Response: read=0 from the next cycle; v_ack and s_ack stay 0; busy=0; rdata=0.
- Enable change in flight:
  - Stimulus: viking_enable cleared at G+2 of a Viking grant, with s_req=1.
  - Response: v_ack still pulses at G+7. The next slot grants the shifter, with streak at 0.
